// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg
//   Shared types and constants for the K&S processor control path.
//   - decoded_instruction_type : one-hot instruction class from the decoder
//   - alu_op_t                 : ALU operation select driven to the datapath
//   - ctrl_state_t             : control FSM state encoding
//   - is_one_hot()             : legality check on a decoded instruction
//   - branch_taken()           : branch-condition evaluation against the flags
package k_and_s_pkg;

  typedef logic [15:0] decoded_instruction_type;

  localparam decoded_instruction_type I_NOP    = 16'h0001;
  localparam decoded_instruction_type I_LOAD   = 16'h0002;
  localparam decoded_instruction_type I_STORE  = 16'h0004;
  localparam decoded_instruction_type I_MOVE   = 16'h0008;
  localparam decoded_instruction_type I_ADD    = 16'h0010;
  localparam decoded_instruction_type I_SUB    = 16'h0020;
  localparam decoded_instruction_type I_AND    = 16'h0040;
  localparam decoded_instruction_type I_OR     = 16'h0080;
  localparam decoded_instruction_type I_BRANCH = 16'h0100;
  localparam decoded_instruction_type I_BZERO  = 16'h0200;
  localparam decoded_instruction_type I_BNZERO = 16'h0400;
  localparam decoded_instruction_type I_BNEG   = 16'h0800;
  localparam decoded_instruction_type I_BNNEG  = 16'h1000;
  localparam decoded_instruction_type I_BOV    = 16'h2000;
  localparam decoded_instruction_type I_BNOV   = 16'h4000;
  localparam decoded_instruction_type I_HALT   = 16'h8000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // State codes kept as plain constants so the encoding stays fixed.
  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t IDLE   = 3'd0;
  localparam ctrl_state_t FETCH  = 3'd1;
  localparam ctrl_state_t DECODE = 3'd2;
  localparam ctrl_state_t EXEC   = 3'd3;
  localparam ctrl_state_t LOAD   = 3'd4;
  localparam ctrl_state_t HALTED = 3'd5;

  // Exactly one bit set (all-zero is not one-hot).
  function automatic logic is_one_hot(input decoded_instruction_type v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  // Taken/not-taken for any branch class; non-branch encodings return 0.
  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero, input logic neg,
                                        input logic ovf);
    logic t;
    t = 1'b0;
    case (instr)
      I_BRANCH: t = 1'b1;
      I_BZERO:  t = zero;
      I_BNZERO: t = !zero;
      I_BNEG:   t = neg;
      I_BNNEG:  t = !neg;
      I_BOV:    t = ovf;
      I_BNOV:   t = !ovf;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/k_and_s_control_unit.sv
// k_and_s_control_unit
//   Control FSM of the K&S processor: IDLE -> FETCH -> DECODE -> EXEC/LOAD/HALTED.
//   Drives datapath enables/selects from registered state, the wait counter and
//   the instruction latched in DECODE.
// Parameters
//   MEM_LAT : RAM read latency in cycles (1..15)
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   decoded_instruction    : one-hot instruction class from the decoder
//   zero/neg/signed_overflow : registered flags from the datapath
//   ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
//   write_reg_enable, flags_reg_enable, ram_write_enable : datapath controls
//   halt, illegal_instr    : sticky status until rst
// Configuration
//   KS_ILLEGAL_TRAP_EN : non-one-hot instructions in DECODE halt with
//                        illegal_instr=1; otherwise they run as NOP and
//                        illegal_instr is tied 0.
module k_and_s_control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero,
  input  logic                    neg,
  input  logic                    signed_overflow,
  output logic                    ir_enable,
  output logic                    pc_enable,
  output logic                    branch,
  output logic                    addr_sel,
  output logic                    c_sel,
  output alu_op_t                 operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    illegal_instr
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  ctrl_state_t             state, state_d;
  logic [3:0]              wait_cnt;
  decoded_instruction_type instr_q;
  logic                    last_cnt;

  assign last_cnt = (wait_cnt == LAST_CNT);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   state_d = FETCH;
      FETCH:  if (last_cnt) state_d = DECODE;
      DECODE: begin
        if (decoded_instruction == I_HALT)      state_d = HALTED;
        else if (decoded_instruction == I_LOAD) state_d = LOAD;
`ifdef KS_ILLEGAL_TRAP_EN
        else if (!is_one_hot(decoded_instruction)) state_d = HALTED;
`endif
        else                                     state_d = EXEC;
      end
      EXEC:   state_d = FETCH;
      LOAD:   if (last_cnt) state_d = FETCH;
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      instr_q  <= '0;
    end else begin
      state <= state_d;
      // Counter only runs while waiting on RAM; any state change restarts it.
      if (state_d != state)
        wait_cnt <= '0;
      else if (state == FETCH || state == LOAD)
        wait_cnt <= wait_cnt + 4'd1;
      if (state == DECODE)
        instr_q <= decoded_instruction;
    end
  end

`ifdef KS_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state == DECODE && decoded_instruction != I_HALT &&
             !is_one_hot(decoded_instruction))
      illegal_q <= 1'b1;
  end
`endif

  // Outputs are a pure decode of state/counter/latched instruction. The flag
  // inputs are already registered in the datapath and are only looked at in
  // EXEC. rst forces everything low so nothing fires in the reset cycle.
  always_comb begin
    ir_enable        = 1'b0;
    pc_enable        = 1'b0;
    branch           = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    illegal_instr    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: if (last_cnt) begin
          ir_enable = 1'b1;
          pc_enable = 1'b1;
        end
        EXEC: begin
          // Exact matches only: non-one-hot encodings fall to default (NOP).
          case (instr_q)
            I_ADD: begin write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = ALU_ADD; end
            I_SUB: begin write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = ALU_SUB; end
            I_AND: begin write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = ALU_AND; end
            I_OR:  begin write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = ALU_OR;  end
            I_MOVE: begin write_reg_enable = 1'b1; operation = ALU_OR; end
            I_STORE: begin addr_sel = 1'b1; ram_write_enable = 1'b1; end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
              branch    = branch_taken(instr_q, zero, neg, signed_overflow);
              pc_enable = branch_taken(instr_q, zero, neg, signed_overflow);
            end
            default: ;
          endcase
        end
        LOAD: begin
          addr_sel = 1'b1;
          if (last_cnt) begin
            write_reg_enable = 1'b1;
            c_sel            = 1'b1;
          end
        end
        HALTED: begin
          halt = 1'b1;
`ifdef KS_ILLEGAL_TRAP_EN
          illegal_instr = illegal_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// tb_k_and_s_control_unit
//   Directed bench for k_and_s_control_unit. dut (MEM_LAT=1) covers reset,
//   every instruction class, branch conditions, illegal encodings, mid-
//   instruction reset and halt; dut3 (MEM_LAT=3) covers FETCH/LOAD latency.
//   Outputs are packed into one control word:
//   {ir, pc, br, addr_sel, c_sel, op[1:0], wr, fl, ram_we, halt, illegal}
module tb_k_and_s_control_unit;
  import k_and_s_pkg::*;

  localparam logic [15:0] M_IR = 16'h0800, M_PC = 16'h0400, M_BR = 16'h0200,
                          M_AS = 16'h0100, M_CS = 16'h0080, OP_SUB = 16'h0020,
                          OP_AND = 16'h0040, OP_OR = 16'h0060, M_WR = 16'h0010,
                          M_FL = 16'h0008, M_RW = 16'h0004, M_H = 16'h0002,
                          M_IL = 16'h0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type di = I_NOP;
  logic zero = 1'b0, neg = 1'b0, ovf = 1'b0;

  logic ir1, pc1, br1, as1, cs1, wr1, fl1, rw1, h1, il1;
  logic [1:0] op1;
  logic ir3, pc3, br3, as3, cs3, wr3, fl3, rw3, h3, il3;
  logic [1:0] op3;

  wire [15:0] ctl1 = {4'b0, ir1, pc1, br1, as1, cs1, op1, wr1, fl1, rw1, h1, il1};
  wire [15:0] ctl3 = {4'b0, ir3, pc3, br3, as3, cs3, op3, wr3, fl3, rw3, h3, il3};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  k_and_s_control_unit #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .decoded_instruction(di),
    .zero(zero), .neg(neg), .signed_overflow(ovf),
    .ir_enable(ir1), .pc_enable(pc1), .branch(br1), .addr_sel(as1),
    .c_sel(cs1), .operation(op1), .write_reg_enable(wr1),
    .flags_reg_enable(fl1), .ram_write_enable(rw1), .halt(h1),
    .illegal_instr(il1)
  );

  k_and_s_control_unit #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .decoded_instruction(di),
    .zero(zero), .neg(neg), .signed_overflow(ovf),
    .ir_enable(ir3), .pc_enable(pc3), .branch(br3), .addr_sel(as3),
    .c_sel(cs3), .operation(op3), .write_reg_enable(wr3),
    .flags_reg_enable(fl3), .ram_write_enable(rw3), .halt(h3),
    .illegal_instr(il3)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold rst for n edges, release, check IDLE then the first FETCH pulse.
  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    chk({tag, ".in_rst"}, ctl1, 16'h0);
    rst = 1'b0;
    #1;
    chk({tag, ".idle"}, ctl1, 16'h0);
    tick();
    chk({tag, ".fetch"}, ctl1, M_IR | M_PC);
  endtask

  // Called in the FETCH cycle that pulses ir_enable; ends in the next one.
  task automatic run_instr(input string tag, input logic [15:0] ins,
                           input logic [2:0] flg, input logic [15:0] exp);
    di = ins;
    {zero, neg, ovf} = flg;
    tick(); chk({tag, ".dec"}, ctl1, 16'h0);
    tick(); chk({tag, ".exe"}, ctl1, exp);
    tick(); chk({tag, ".nxt"}, ctl1, M_IR | M_PC);
  endtask

  typedef struct packed {
    logic [15:0] ins;
    logic [2:0]  flg;   // {zero, neg, ovf}
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{I_ADD,    3'b000, M_WR | M_FL};
    vecs[1]  = '{I_SUB,    3'b000, M_WR | M_FL | OP_SUB};
    vecs[2]  = '{I_AND,    3'b000, M_WR | M_FL | OP_AND};
    vecs[3]  = '{I_OR,     3'b000, M_WR | M_FL | OP_OR};
    vecs[4]  = '{I_MOVE,   3'b000, M_WR | OP_OR};
    vecs[5]  = '{I_STORE,  3'b000, M_AS | M_RW};
    vecs[6]  = '{I_BRANCH, 3'b000, M_BR | M_PC};
    vecs[7]  = '{I_NOP,    3'b111, 16'h0};
    vecs[8]  = '{I_LOAD,   3'b000, M_AS | M_WR | M_CS};
    vecs[9]  = '{I_BZERO,  3'b100, M_BR | M_PC};
    vecs[10] = '{I_BZERO,  3'b000, 16'h0};
    vecs[11] = '{I_BNZERO, 3'b000, M_BR | M_PC};
    vecs[12] = '{I_BNEG,   3'b010, M_BR | M_PC};
    vecs[13] = '{I_BNNEG,  3'b010, 16'h0};
    vecs[14] = '{I_BOV,    3'b001, M_BR | M_PC};
    vecs[15] = '{I_BNOV,   3'b001, 16'h0};
    vecs[16] = '{I_BNNEG,  3'b101, M_BR | M_PC};

    do_reset(3, "reset");

    for (int i = 0; i < 17; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].flg, vecs[i].exp);

`ifdef KS_ILLEGAL_TRAP_EN
    di = 16'h0003;
    tick(); chk("ill3.dec", ctl1, 16'h0);
    tick(); chk("ill3.trap", ctl1, M_H | M_IL);
    tick(); chk("ill3.hold", ctl1, M_H | M_IL);
    do_reset(1, "ill3.rst");
    di = 16'h0000;
    tick(); chk("ill0.dec", ctl1, 16'h0);
    tick(); chk("ill0.trap", ctl1, M_H | M_IL);
    do_reset(1, "ill0.rst");
`else
    run_instr("ill3", 16'h0003, 3'b111, 16'h0);
    run_instr("ill0", 16'h0000, 3'b111, 16'h0);
`endif

    // Reset landing in an ALU EXEC cycle must suppress its enables.
    di = I_ADD;
    tick(); chk("mid.dec", ctl1, 16'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid.rst_exec", ctl1, 16'h0);
    do_reset(1, "mid");

    // Halt is sticky until rst.
    di = I_HALT;
    tick(); chk("halt.dec", ctl1, 16'h0);
    tick(); chk("halt.enter", ctl1, M_H);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("halt.hold%0d", i), ctl1, M_H);
    end
    do_reset(1, "halt.rst");

    // MEM_LAT=3: 3-cycle FETCH, 3-cycle LOAD, 7 cycles per LOAD.
    di = I_LOAD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("l3.idle", ctl3, 16'h0);
    tick(); chk("l3.f0", ctl3, 16'h0);
    tick(); chk("l3.f1", ctl3, 16'h0);
    tick(); chk("l3.f2", ctl3, M_IR | M_PC);
    tick(); chk("l3.dec", ctl3, 16'h0);
    tick(); chk("l3.ld0", ctl3, M_AS);
    tick(); chk("l3.ld1", ctl3, M_AS);
    tick(); chk("l3.ld2", ctl3, M_AS | M_WR | M_CS);
    tick(); chk("l3.nf0", ctl3, 16'h0);
    tick(); chk("l3.nf1", ctl3, 16'h0);
    tick(); chk("l3.nf2", ctl3, M_IR | M_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
